// File: rtl/swervolf_multitimer.sv
// Multi-channel countdown timer with a shared prescaler and a Wishbone
// register interface. Each channel counts down from LOAD on prescaler ticks,
// flags a pending bit when it expires, and can reload periodically.
module swervolf_multitimer #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [7:0]      i_wb_adr,
  input  logic [31:0]     i_wb_dat,
  input  logic [3:0]      i_wb_sel,
  input  logic            i_wb_we,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  output logic [31:0]     o_wb_rdt,
  output logic            o_wb_ack,
  output logic [N_CH-1:0] o_irq_vec,
  output logic            o_irq
);

  logic             run_q, run_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  irqen_q, irqen_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] load_q  [N_CH];
  logic [CNT_W-1:0] load_d  [N_CH];
  logic [CNT_W-1:0] count_q [N_CH];
  logic [CNT_W-1:0] count_d [N_CH];
  logic [N_CH-1:0]  en_q, en_d;
  logic [N_CH-1:0]  per_q, per_d;
  logic [N_CH-1:0]  expire;
  logic [N_CH-1:0]  w1c;
  logic             ack_q, ack_d;
  logic [31:0]      rdt_q, rdt_d;
  logic             irq_q;

  logic       acc;
  logic       wr;
  logic       tick;
  logic       glb;
  logic [3:0] blk;
  logic [1:0] sub;
  logic       unused_adr;

  // Address decode: bits [7:4] pick the 16-byte block (0 = globals,
  // 1+i = channel i), bits [3:2] pick the word inside the block.
  assign blk        = i_wb_adr[7:4];
  assign sub        = i_wb_adr[3:2];
  assign glb        = (blk == 4'd0);
  assign unused_adr = ^i_wb_adr[1:0];

  assign acc  = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wr   = acc & i_wb_we;
  assign tick = run_q & (pcnt_q == pre_q);

  assign ack_d = i_wb_cyc & i_wb_stb & ~ack_q;

  assign o_wb_ack  = ack_q;
  assign o_wb_rdt  = rdt_q;
  assign o_irq_vec = pend_q & irqen_q;
  assign o_irq     = irq_q;

  // Global registers, prescaler and pending bits (hardware set beats W1C).
  always_comb begin
    run_d   = run_q;
    irqen_d = irqen_q;
    pre_d   = pre_q;
    w1c     = '0;
    if (wr && glb) begin
      case (sub)
        2'd0: if (i_wb_sel[0]) run_d = i_wb_dat[0];
        2'd1: if (i_wb_sel[0]) w1c = i_wb_dat[N_CH-1:0];
        2'd2: if (i_wb_sel[0]) irqen_d = i_wb_dat[N_CH-1:0];
        default: begin
          for (int unsigned k = 0; k < PRE_W; k++) begin
            if (i_wb_sel[2'(k >> 3)]) pre_d[k] = i_wb_dat[k];
          end
        end
      endcase
    end
    if (!run_q || tick) pcnt_d = '0;
    else                pcnt_d = pcnt_q + PRE_W'(1);
    pend_d = (pend_q & ~w1c) | expire;
  end

  // Per-channel countdown; a CCTRL write overrides the expiry update of en
  // and COUNT, while the expiry still reaches the pending bit.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      load_d[i]  = load_q[i];
      count_d[i] = count_q[i];
      en_d[i]    = en_q[i];
      per_d[i]   = per_q[i];
      expire[i]  = tick & en_q[i] & (count_q[i] == CNT_W'(1));
      if (tick && en_q[i]) begin
        if (expire[i]) begin
          if (per_q[i]) begin
            count_d[i] = load_q[i];
            if (load_q[i] == '0) en_d[i] = 1'b0;
          end else begin
            count_d[i] = '0;
            en_d[i]    = 1'b0;
          end
        end else if (count_q[i] > CNT_W'(1)) begin
          count_d[i] = count_q[i] - CNT_W'(1);
        end
      end
      if (wr && (blk == 4'(i + 1))) begin
        if (sub == 2'd0) begin
          for (int unsigned k = 0; k < CNT_W; k++) begin
            if (i_wb_sel[2'(k >> 3)]) load_d[i][k] = i_wb_dat[k];
          end
        end
        if (sub == 2'd2 && i_wb_sel[0]) begin
          en_d[i]  = i_wb_dat[0] & (load_q[i] != '0);
          per_d[i] = i_wb_dat[1];
          if (i_wb_dat[0]) count_d[i] = load_q[i];
        end
      end
    end
  end

  // Read mux, captured in the acknowledge cycle; unmapped space reads zero.
  always_comb begin
    rdt_d = '0;
    if (acc) begin
      if (glb) begin
        case (sub)
          2'd0:    rdt_d[0]          = run_q;
          2'd1:    rdt_d[N_CH-1:0]   = pend_q;
          2'd2:    rdt_d[N_CH-1:0]   = irqen_q;
          default: rdt_d[PRE_W-1:0]  = pre_q;
        endcase
      end
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (blk == 4'(i + 1)) begin
          case (sub)
            2'd0:    rdt_d[CNT_W-1:0] = load_q[i];
            2'd1:    rdt_d[CNT_W-1:0] = count_q[i];
            2'd2:    rdt_d[1:0]       = {per_q[i], en_q[i]};
            default: rdt_d            = '0;
          endcase
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run_q   <= 1'b0;
      pend_q  <= '0;
      irqen_q <= '0;
      pre_q   <= '0;
      pcnt_q  <= '0;
      en_q    <= '0;
      per_q   <= '0;
      ack_q   <= 1'b0;
      rdt_q   <= '0;
      irq_q   <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        load_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      run_q   <= run_d;
      pend_q  <= pend_d;
      irqen_q <= irqen_d;
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
      en_q    <= en_d;
      per_q   <= per_d;
      ack_q   <= ack_d;
      rdt_q   <= rdt_d;
      irq_q   <= |o_irq_vec;
      for (int unsigned i = 0; i < N_CH; i++) begin
        load_q[i]  <= load_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

endmodule

// File: tb/tb_swervolf_multitimer.sv
// Bench for swervolf_multitimer: a cycle model computes the expected bus and
// interrupt outputs from the register rules, checked every cycle, plus
// directed scenarios with literal expectations.
module tb_swervolf_multitimer;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic [3:0]  o_irq_vec;
  logic        o_irq;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc_n  = 0;
  int unsigned last_edge = 0;
  bit          chk_on = 1'b0;

  swervolf_multitimer #(.N_CH(4), .CNT_W(32), .PRE_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_rdt(o_wb_rdt),
    .o_wb_ack(o_wb_ack), .o_irq_vec(o_irq_vec), .o_irq(o_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_run;
  bit [3:0]    m_pend, m_irqen;
  int unsigned m_pre, m_pcnt;
  int unsigned m_load [NCH];
  int unsigned m_cnt  [NCH];
  bit          m_en   [NCH];
  bit          m_per  [NCH];
  bit          m_ack, m_irq;
  logic [31:0] m_rdt;

  function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    int blkn, subn;
    blkn = a / 16;
    subn = (a / 4) % 4;
    if (blkn == 0) begin
      case (subn)
        0: return 32'(m_run);
        1: return 32'(m_pend);
        2: return 32'(m_irqen);
        default: return m_pre;
      endcase
    end else if (blkn <= NCH) begin
      case (subn)
        0: return m_load[blkn-1];
        1: return m_cnt[blkn-1];
        2: return 32'(2 * int'(m_per[blkn-1]) + int'(m_en[blkn-1]));
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  always @(posedge clk) begin : model
    bit          acc, wr, tick, nrun;
    bit [3:0]    exp_v, w1c, nirqen;
    int          a, blkn, subn;
    int unsigned npre;
    int unsigned nl [NCH];
    int unsigned nc [NCH];
    bit          ne [NCH];
    bit          np [NCH];
    if (rst) begin
      m_run <= 0; m_pend <= '0; m_irqen <= '0; m_pre <= 0; m_pcnt <= 0;
      m_ack <= 0; m_irq <= 0; m_rdt <= '0;
      for (int i = 0; i < NCH; i++) begin
        m_load[i] <= 0; m_cnt[i] <= 0; m_en[i] <= 0; m_per[i] <= 0;
      end
    end else begin
      acc  = cyc && stb && !m_ack;
      wr   = acc && we;
      a    = int'(adr);
      blkn = a / 16;
      subn = (a / 4) % 4;
      tick = m_run && (m_pcnt == m_pre);
      nrun = m_run; nirqen = m_irqen; npre = m_pre; w1c = '0; exp_v = '0;
      for (int i = 0; i < NCH; i++) begin
        nl[i] = m_load[i]; nc[i] = m_cnt[i]; ne[i] = m_en[i]; np[i] = m_per[i];
        if (tick && m_en[i]) begin
          if (m_cnt[i] == 1) begin
            exp_v[i] = 1'b1;
            if (m_per[i]) begin nc[i] = m_load[i]; ne[i] = (m_load[i] != 0); end
            else          begin nc[i] = 0;         ne[i] = 1'b0; end
          end else if (m_cnt[i] > 1) begin
            nc[i] = m_cnt[i] - 1;
          end
        end
      end
      if (wr) begin
        if (blkn == 0) begin
          if (subn == 0 && sel[0]) nrun   = dat[0];
          if (subn == 1 && sel[0]) w1c    = dat[3:0];
          if (subn == 2 && sel[0]) nirqen = dat[3:0];
          if (subn == 3)           npre   = byte_merge(m_pre, dat, sel) % 65536;
        end else if (blkn <= NCH) begin
          if (subn == 0) nl[blkn-1] = byte_merge(m_load[blkn-1], dat, sel);
          if (subn == 2 && sel[0]) begin
            ne[blkn-1] = dat[0] && (m_load[blkn-1] != 0);
            np[blkn-1] = dat[1];
            if (dat[0]) nc[blkn-1] = m_load[blkn-1];
          end
        end
      end
      m_run   <= nrun;
      m_irqen <= nirqen;
      m_pre   <= npre;
      m_pcnt  <= (!m_run || tick) ? 0 : m_pcnt + 1;
      m_pend  <= (m_pend & ~w1c) | exp_v;
      m_irq   <= |(m_pend & m_irqen);
      m_ack   <= cyc && stb && !m_ack;
      m_rdt   <= acc ? m_read(a) : 32'd0;
      for (int i = 0; i < NCH; i++) begin
        m_load[i] <= nl[i]; m_cnt[i] <= nc[i]; m_en[i] <= ne[i]; m_per[i] <= np[i];
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack",     32'(o_wb_ack),  32'(m_ack));
      chk("irq",     32'(o_irq),     32'(m_irq));
      chk("irq_vec", 32'(o_irq_vec), 32'(m_pend & m_irqen));
      chk("rdt",     o_wb_rdt,       m_rdt);
    end
  end

  // ---------------- bus helpers (called and return at a negedge) ----------------
  task automatic wb_xfer(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit w, output logic [31:0] r);
    bit got;
    got = 1'b0;
    adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (o_wb_ack) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wb_ack_timeout actual=no_ack required=ack adr=%h", a);
    end
    last_edge = cyc_n;
    r = o_wb_rdt;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(a, d, s, 1'b1, dummy);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] r);
    wb_xfer(a, 32'd0, 4'hF, 1'b0, r);
  endtask

  task automatic wait_to(input int unsigned e);
    while (cyc_n < e) @(negedge clk);
  endtask

  task automatic wait_irq0(output int unsigned d);
    bit found;
    found = 1'b0;
    d = 0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      if (o_irq_vec[0]) begin found = 1'b1; d = cyc_n; break; end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL irq0_timeout actual=low required=high");
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] r;
    int unsigned p, g, c, d;
    bit exp_pat [4];
    exp_pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    rst = 1'b1; adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(o_wb_ack), 32'd0);
    chk("rst_irq", 32'(o_irq), 32'd0);
    chk("rst_vec", 32'(o_irq_vec), 32'd0);
    chk("rst_rdt", o_wb_rdt, 32'd0);
    chk_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // held request -> ack toggles
    adr = 8'h00; cyc = 1'b1; stb = 1'b1; we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("proto_ack", 32'(o_wb_ack), 32'(exp_pat[k]));
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    rd(8'hFC, r); chk("rd_unmapped_fc", r, 32'd0);
    rd(8'h1C, r); chk("rd_unused_word", r, 32'd0);
    rd(8'h50, r); chk("rd_channel4", r, 32'd0);

    // byte lanes
    wr(8'h10, 32'hAABBCCDD, 4'b0101);
    rd(8'h10, r); chk("load_bytelane", r, 32'h00BB00DD);
    wr(8'h14, 32'h12345678, 4'hF);
    rd(8'h14, r); chk("count_readonly", r, 32'd0);
    wr(8'h0C, 32'hFFFFFFFF, 4'b0010);
    rd(8'h0C, r); chk("prescale_bytelane", r, 32'h0000FF00);
    wr(8'h0C, 32'd0, 4'hF);

    // one-shot
    wr(8'h10, 32'd5, 4'hF);
    wr(8'h08, 32'd1, 4'hF);
    wr(8'h00, 32'd1, 4'hF);
    wr(8'h18, 32'd1, 4'hF);
    p = last_edge;
    wait_irq0(d);
    chk("oneshot_latency", d - p, 32'd5);
    chk("oneshot_irq_lag0", 32'(o_irq), 32'd0);
    @(posedge clk); #1;
    chk("oneshot_irq_lag1", 32'(o_irq), 32'd1);
    @(negedge clk);
    rd(8'h14, r); chk("oneshot_count0", r, 32'd0);
    rd(8'h18, r); chk("oneshot_en0", r, 32'd0);
    wr(8'h04, 32'd1, 4'hF);
    chk("oneshot_w1c", 32'(o_irq_vec[0]), 32'd0);

    // periodic, prescale 3, load 2 -> expiry every 8 cycles
    wr(8'h00, 32'd0, 4'hF);
    wr(8'h0C, 32'd3, 4'hF);
    wr(8'h10, 32'd2, 4'hF);
    wr(8'h18, 32'd3, 4'hF);
    wr(8'h00, 32'd1, 4'hF);
    g = last_edge;
    wait_irq0(d);
    chk("periodic_first", d - g, 32'd8);
    wait_to(g + 9);
    wr(8'h04, 32'd1, 4'hF);
    chk("periodic_w1c_clear", 32'(o_irq_vec[0]), 32'd0);
    wait_irq0(d);
    chk("periodic_second", d - g, 32'd16);
    wait_to(g + 19);
    wr(8'h04, 32'd1, 4'hF);
    chk("periodic_w1c_clear2", 32'(o_irq_vec[0]), 32'd0);
    wait_to(g + 23);
    wr(8'h04, 32'd1, 4'hF);
    chk("w1c_edge_align", last_edge - g, 32'd24);
    chk("set_beats_w1c", 32'(o_irq_vec[0]), 32'd1);
    wr(8'h18, 32'd0, 4'hF);
    wr(8'h00, 32'd0, 4'hF);
    wr(8'h0C, 32'd0, 4'hF);
    wr(8'h04, 32'hF, 4'hF);

    // CCTRL write coinciding with an expiry
    wr(8'h00, 32'd1, 4'hF);
    wr(8'h10, 32'd3, 4'hF);
    wr(8'h18, 32'd3, 4'hF);
    c = last_edge;
    wait_to(c + 3);
    wr(8'h04, 32'd1, 4'hF);
    chk("coinc_pre_w1c", 32'(o_irq_vec[0]), 32'd0);
    wait_to(c + 5);
    wr(8'h18, 32'd1, 4'hF);
    chk("coinc_pending", 32'(o_irq_vec[0]), 32'd1);
    rd(8'h14, r); chk("coinc_count", r, 32'd2);
    rd(8'h18, r); chk("coinc_oneshot_done", r, 32'd0);
    wr(8'h00, 32'd0, 4'hF);
    wr(8'h04, 32'hF, 4'hF);

    // all four channels
    for (int i = 0; i < 4; i++) wr(8'(16 * i + 16), 32'(i + 1), 4'hF);
    wr(8'h08, 32'hA, 4'hF);
    for (int i = 0; i < 4; i++) wr(8'(16 * i + 24), 32'd1, 4'hF);
    wr(8'h00, 32'd1, 4'hF);
    repeat (8) @(negedge clk);
    rd(8'h04, r); chk("multi_status", r, 32'hF);
    chk("multi_vec", 32'(o_irq_vec), 32'hA);
    chk("multi_irq", 32'(o_irq), 32'd1);

    // enable with LOAD=0 stays disabled
    wr(8'h20, 32'd0, 4'hF);
    wr(8'h28, 32'd3, 4'hF);
    rd(8'h28, r); chk("load0_en", r, 32'd2);

    // reset in the middle of a count and of an access
    wr(8'h10, 32'd100, 4'hF);
    wr(8'h18, 32'd1, 4'hF);
    repeat (5) @(negedge clk);
    rst = 1'b1; adr = 8'h04; cyc = 1'b1; stb = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ack", 32'(o_wb_ack), 32'd0);
    chk("midrst_irq", 32'(o_irq), 32'd0);
    chk("midrst_vec", 32'(o_irq_vec), 32'd0);
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rd(8'(4 * k), r);
      chk("midrst_reg", r, 32'd0);
    end
    chk("midrst_irq_after", 32'(o_irq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swervolf_multitimer.md
SWERVOLF_MULTITIMER -- requirements
Module: swervolf_multitimer

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of countdown channels, legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 32: channel counter width, legal range 8..32.
REQ-003 SHALL have parameter PRE_W, default 16: prescaler width, legal range 1..16.
REQ-004 SHALL have port i_clk, input, 1: clock; all state changes on rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port i_wb_adr, input, 8: byte address; bits [7:2] select the word.
REQ-007 SHALL have ports i_wb_dat (input, 32), i_wb_sel (input, 4), i_wb_we, i_wb_cyc and i_wb_stb (input, 1 each): Wishbone slave request.
REQ-008 SHALL have ports o_wb_rdt (output, 32) and o_wb_ack (output, 1): Wishbone read data and acknowledge.
REQ-009 SHALL have port o_irq_vec, output, N_CH: per-channel pending AND enable.
REQ-010 SHALL have port o_irq, output, 1: OR-reduction of o_irq_vec, registered.

Function
REQ-011 SHALL drive o_wb_ack <= i_wb_cyc & i_wb_stb & !o_wb_ack, giving one-cycle acks and back-to-back accesses separated by one idle cycle.
REQ-012 SHALL perform a write only when cyc & stb & we & !o_wb_ack; o_wb_rdt SHALL be registered in the same cycle as the ack.
REQ-013 SHALL implement this word map:
- 0x00 GCTRL: bit0 global run.
- 0x04 STATUS: [N_CH-1:0] pending, write-1-to-clear.
- 0x08 IRQEN: [N_CH-1:0].
- 0x0C PRESCALE: [PRE_W-1:0].
- Channel i at 0x10+0x10*i: +0 LOAD [CNT_W-1:0]; +4 COUNT, read-only; +8 CCTRL (bit0 en, bit1 periodic).
REQ-014 SHALL honour i_wb_sel per byte for LOAD and PRESCALE; GCTRL, STATUS, IRQEN and CCTRL SHALL use sel[0] only.
REQ-015 SHALL return 0 for unmapped reads, unused bits, and channels at index N_CH or above; writes to those locations SHALL be ignored.
REQ-016 Prescaler: while GCTRL.run=1, pre_cnt SHALL increment each cycle; when pre_cnt==PRESCALE, tick=1 and pre_cnt wraps to 0. PRESCALE=0 SHALL produce a tick every cycle; run=0 SHALL hold pre_cnt at 0.
REQ-017 A CCTRL write with en=1 SHALL set COUNT<=LOAD in the next cycle; if LOAD==0, en SHALL stay 0.
REQ-018 On a tick with en=1 and COUNT>1, COUNT SHALL decrement by 1.
REQ-019 On a tick with en=1 and COUNT==1:
- pending[i] SHALL be set.
- If periodic=1, COUNT SHALL reload from LOAD; if LOAD==0 at that point, en SHALL clear.
- If periodic=0, COUNT SHALL become 0 and en SHALL clear.
REQ-020 A LOAD write while running SHALL not affect COUNT until the next reload.
REQ-021 When a hardware set and a W1C of the same pending bit occur in one cycle, set SHALL win.
REQ-022 A CCTRL write coinciding with a channel expiry SHALL take precedence for en and COUNT; pending SHALL still be set.
REQ-023 o_irq_vec SHALL be combinational from pending & IRQEN; o_irq SHALL lag o_irq_vec by one cycle.
REQ-024 COUNT arithmetic SHALL be unsigned CNT_W-bit and SHALL never wrap below 0.

Reset
REQ-025 i_rst SHALL clear GCTRL, STATUS, IRQEN, PRESCALE, pre_cnt, all LOAD, COUNT and CCTRL, and drive o_wb_ack, o_irq, o_irq_vec and o_wb_rdt to 0.
REQ-026 i_rst mid-count or mid-access SHALL take effect at the next edge; no ack SHALL be issued for the aborted cycle.

Verification
REQ-027 One-shot: PRESCALE=0, LOAD=5, IRQEN=1, run=1, then write CCTRL=1 -> pending[0] set exactly 5 cycles after COUNT loads; en=0; COUNT=0; o_irq high one cycle after pending.
REQ-028 Periodic: PRESCALE=3, LOAD=2, CCTRL=3 -> pending asserts every 8 cycles; W1C in a cycle with no expiry clears it; W1C coinciding with an expiry leaves it set.
REQ-029 Byte lanes: write 0xAABBCCDD to LOAD with sel=0b0101 -> LOAD reads 0x00BB00DD; a write to COUNT is ignored.
REQ-030 Multi-channel: N_CH=4, channels 0-3 with LOAD 1..4 and IRQEN=0b1010 -> STATUS reaches 0xF; o_irq_vec=0b1010.
REQ-031 Edge cases: CCTRL en with LOAD=0 -> en reads 0; i_rst asserted mid-count -> all registers read 0 and o_irq=0.
REQ-032 Bus protocol: cyc/stb held high for 4 cycles -> ack toggles 1,0,1,0; a read of 0xFC returns 0.
